// File: rtl/inc_sequencer.sv
// Tiny programmable incrementer: a 3-state FSM steps through a small
// instruction memory of INC / JNO / HALT / NOP words driving an accumulator.
module inc_sequencer #(
  parameter int DATA_W = 4,
  parameter int PC_W   = 3,
  parameter logic [DATA_W-1:0] STEP = {{(DATA_W-1){1'b0}}, 1'b1}
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              run,
  input  logic              prog_we,
  input  logic [PC_W-1:0]   prog_addr,
  input  logic [PC_W+1:0]   prog_wdata,
  output logic [DATA_W-1:0] acc,
  output logic              status,
  output logic [PC_W-1:0]   pc,
  output logic              halted
);

  localparam int DEPTH = 2 ** PC_W;
  localparam int IW    = PC_W + 2;

  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_JNO  = 2'b01;
  localparam logic [1:0] OP_HALT = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;

  localparam logic [PC_W-1:0]   PC_ZERO   = {PC_W{1'b0}};
  localparam logic [PC_W-1:0]   PC_ONE    = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] ACC_ZERO  = {DATA_W{1'b0}};
  localparam logic [IW-1:0]     HALT_WORD = {OP_HALT, PC_ZERO};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t              state_r;
  logic [IW-1:0]       mem_r [DEPTH];
  logic [DATA_W-1:0]   acc_r;
  logic                status_r;
  logic [PC_W-1:0]     pc_r;
  logic                halted_r;

  logic [IW-1:0]       instr_s;
  logic [1:0]          opcode_s;
  logic [PC_W-1:0]     target_s;
  logic [PC_W-1:0]     pc_inc_s;
  logic [DATA_W:0]     sum_s;

  // Instruction fetch and datapath arithmetic for the current pc
  always_comb begin
    instr_s  = mem_r[pc_r];
    opcode_s = instr_s[IW-1 -: 2];
    target_s = instr_s[PC_W-1:0];
    pc_inc_s = pc_r + PC_ONE;
    sum_s    = {1'b0, acc_r} + {1'b0, STEP};
  end

  // Program memory: reset fills every word with HALT; writes land only while idle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= HALT_WORD;
      end
    end else if (prog_we && (state_r == IDLE)) begin
      mem_r[prog_addr] <= prog_wdata;
    end
  end

  // Sequencer FSM with registered accumulator, flag, pc and halted output
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      acc_r    <= ACC_ZERO;
      status_r <= 1'b0;
      pc_r     <= PC_ZERO;
      halted_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          halted_r <= 1'b0;
          if (run) begin
            acc_r    <= ACC_ZERO;
            status_r <= 1'b0;
            pc_r     <= PC_ZERO;
            state_r  <= EXEC;
          end
        end
        EXEC: begin
          // Dropping run abandons the pending instruction with all state held
          if (!run) begin
            state_r  <= IDLE;
            halted_r <= 1'b0;
          end else begin
            case (opcode_s)
              OP_INC: begin
                acc_r <= sum_s[DATA_W-1:0];
                pc_r  <= pc_inc_s;
                if (sum_s[DATA_W]) begin
                  status_r <= 1'b1;
                end
              end
              OP_JNO: begin
                pc_r <= status_r ? pc_inc_s : target_s;
              end
              OP_HALT: begin
                state_r  <= HALT;
                halted_r <= 1'b1;
              end
              OP_NOP: begin
                pc_r <= pc_inc_s;
              end
              default: begin
                state_r  <= IDLE;
                halted_r <= 1'b0;
              end
            endcase
          end
        end
        HALT: begin
          if (!run) begin
            state_r  <= IDLE;
            halted_r <= 1'b0;
          end else begin
            halted_r <= 1'b1;
          end
        end
        default: begin
          state_r  <= IDLE;
          halted_r <= 1'b0;
        end
      endcase
    end
  end

  assign acc    = acc_r;
  assign status = status_r;
  assign pc     = pc_r;
  assign halted = halted_r;

endmodule

// File: tb/tb_inc_sequencer.sv
// Directed bench for inc_sequencer: expected {acc,status,pc,halted} tuples are
// queued as each step is driven and popped for comparison once the DUT responds.
module tb_inc_sequencer;

  logic       clock;
  logic       reset_n;
  logic       run;
  logic       prog_we;
  logic [2:0] prog_addr;
  logic [4:0] prog_wdata;
  logic [3:0] acc;
  logic       status;
  logic [2:0] pc;
  logic       halted;

  localparam logic [4:0] W_INC  = 5'b00_000;
  localparam logic [4:0] W_JNO0 = 5'b01_000;
  localparam logic [4:0] W_NOP  = 5'b11_000;

  int checks = 0;
  int passed = 0;
  int failed = 0;
  logic [8:0] exp_q [$];

  inc_sequencer dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .run        (run),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .acc        (acc),
    .status     (status),
    .pc         (pc),
    .halted     (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic expect_state(input logic [3:0] a, input logic s, input logic [2:0] p,
                              input logic h);
    exp_q.push_back({a, s, p, h});
  endtask

  task automatic check(input string tag);
    logic [8:0] e;
    logic [8:0] o;
    e = exp_q.pop_front();
    o = {acc, status, pc, halted};
    checks++;
    assert (o === e) passed++;
    else begin
      failed++;
      $error("FAIL %s observed acc=%0d status=%0b pc=%0d halted=%0b expected acc=%0d status=%0b pc=%0d halted=%0b",
             tag, o[8:5], o[4], o[3:1], o[0], e[8:5], e[4], e[3:1], e[0]);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] a, input logic s,
                      input logic [2:0] p, input logic h);
    expect_state(a, s, p, h);
    @(posedge clock);
    #1;
    check(tag);
  endtask

  task automatic wr(input logic [2:0] addr, input logic [4:0] data);
    prog_we    = 1'b1;
    prog_addr  = addr;
    prog_wdata = data;
    @(posedge clock);
    #1;
    prog_we = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    run        = 1'b0;
    prog_we    = 1'b0;
    prog_addr  = 3'd0;
    prog_wdata = 5'd0;
    #1;
    expect_state(4'd0, 1'b0, 3'd0, 1'b0);
    check("reset_values");
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Unloaded memory halts at address 0
    step("idle_run0", 4'd0, 1'b0, 3'd0, 1'b0);
    run = 1'b1;
    step("enter_exec", 4'd0, 1'b0, 3'd0, 1'b0);
    step("empty_halt", 4'd0, 1'b0, 3'd0, 1'b1);
    step("halt_persist", 4'd0, 1'b0, 3'd0, 1'b1);
    run = 1'b0;
    step("halt_exit", 4'd0, 1'b0, 3'd0, 1'b0);

    // INC / JNO 0 loop until the accumulator wraps
    wr(3'd0, W_INC);
    wr(3'd1, W_JNO0);
    run = 1'b1;
    step("loop_start", 4'd0, 1'b0, 3'd0, 1'b0);
    for (int k = 1; k <= 15; k++) begin
      if (k == 3) begin
        prog_we    = 1'b1;
        prog_addr  = 3'd2;
        prog_wdata = W_INC;
      end
      step("loop_inc", 4'(k), 1'b0, 3'd1, 1'b0);
      prog_we = 1'b0;
      step("loop_jno", 4'(k), 1'b0, 3'd0, 1'b0);
    end
    step("wrap_carry", 4'd0, 1'b1, 3'd1, 1'b0);
    step("jno_fall", 4'd0, 1'b1, 3'd2, 1'b0);
    step("addr2_halt", 4'd0, 1'b1, 3'd2, 1'b1);
    step("halt_hold", 4'd0, 1'b1, 3'd2, 1'b1);

    // Abort mid-loop, then restart
    run = 1'b0;
    step("halt_to_idle", 4'd0, 1'b1, 3'd2, 1'b0);
    run = 1'b1;
    step("restart_clear", 4'd0, 1'b0, 3'd0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      step("run2_inc", 4'(k), 1'b0, 3'd1, 1'b0);
      if (k < 5) step("run2_jno", 4'(k), 1'b0, 3'd0, 1'b0);
    end
    run = 1'b0;
    step("abort_hold", 4'd5, 1'b0, 3'd1, 1'b0);
    step("idle_hold", 4'd5, 1'b0, 3'd1, 1'b0);
    run = 1'b1;
    step("rerun_clear", 4'd0, 1'b0, 3'd0, 1'b0);
    step("rerun_inc", 4'd1, 1'b0, 3'd1, 1'b0);

    // All-NOP program: pc walks and wraps
    run = 1'b0;
    step("to_idle", 4'd1, 1'b0, 3'd1, 1'b0);
    for (int i = 0; i < 8; i++) wr(3'(i), W_NOP);
    run = 1'b1;
    step("nop_start", 4'd0, 1'b0, 3'd0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step("nop_walk", 4'd0, 1'b0, 3'(i % 8), 1'b0);
    end

    // Write at address 0 on the starting edge is fetched
    run = 1'b0;
    step("nop_idle", 4'd0, 1'b0, 3'd0, 1'b0);
    wr(3'd1, W_JNO0);
    prog_we    = 1'b1;
    prog_addr  = 3'd0;
    prog_wdata = W_INC;
    run        = 1'b1;
    step("write_and_run", 4'd0, 1'b0, 3'd0, 1'b0);
    prog_we = 1'b0;
    step("fetch_new_word", 4'd1, 1'b0, 3'd1, 1'b0);
    step("rst_pre_jno", 4'd1, 1'b0, 3'd0, 1'b0);
    step("rst_pre_inc", 4'd2, 1'b0, 3'd1, 1'b0);

    // Asynchronous reset between edges, then memory is back to HALT
    #3;
    reset_n = 1'b0;
    #1;
    expect_state(4'd0, 1'b0, 3'd0, 1'b0);
    check("async_reset");
    step("in_reset", 4'd0, 1'b0, 3'd0, 1'b0);
    reset_n = 1'b1;
    step("post_reset_start", 4'd0, 1'b0, 3'd0, 1'b0);
    step("mem_cleared_halt", 4'd0, 1'b0, 3'd0, 1'b1);

    checks++;
    assert (exp_q.size() == 0) passed++;
    else begin
      failed++;
      $error("FAIL scoreboard_drain observed %0d left expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
